// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller.
//   run_state_t    : controller FSM states
//   DEFAULT_BUDGET : cycle budget used by the implicit start taken when
//                    RUN_CTRL_AUTOSTART_EN is defined
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEQ,
        RUN,
        DONE,
        TIMEOUT
    } run_state_t;

    localparam int DEFAULT_BUDGET = 500;

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously with arst and deasserts
// synchronously after SYNC_STAGES rising edges of clk.
//   clk  : clock
//   arst : asynchronous active-high reset input
//   rst  : synchronised active-high reset output
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arst,
    output logic rst
);

    logic [SYNC_STAGES-1:0] chain_reg;

    // A one shifts in from the bottom; reset is released once it reaches the top.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst = ~chain_reg[SYNC_STAGES-1];

endmodule

// File: rtl/run_ctrl.sv
// Run controller: synchronises the board reset, releases N_CH active-low
// domain resets in a staggered order, then counts run cycles against a
// programmable budget, ending on halt_req (done) or exhaustion (timeout).
//   clk_50    : system clock
//   arst      : asynchronous active-high reset
//   start     : run request (IDLE/DONE/TIMEOUT only)
//   budget    : cycle budget latched on accepted start, 0 = unlimited
//   halt_req  : processor halt, honoured in RUN only
//   rst_n_out : per-domain active-low resets
//   running   : high in RUN
//   done      : run ended by halt_req
//   timeout   : run ended by budget exhaustion
//   cycles    : executed cycle count
// Build option: RUN_CTRL_AUTOSTART_EN takes an implicit start with
// DEFAULT_BUDGET on the first edge after internal reset release.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int STAGGER     = 2,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_50,
    input  logic             arst,
    input  logic             start,
    input  logic [CNT_W-1:0] budget,
    input  logic             halt_req,
    output logic [N_CH-1:0]  rst_n_out,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycles
);

    localparam int IDX_W = $clog2(N_CH + 1);
    localparam int STG_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    logic rst;

    rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
        .clk  (clk_50),
        .arst (arst),
        .rst  (rst)
    );

    run_state_t       state_reg,   state_next;
    logic [N_CH-1:0]  rst_n_reg,   rst_n_next;
    logic             running_reg, running_next;
    logic             done_reg,    done_next;
    logic             timeout_reg, timeout_next;
    logic [CNT_W-1:0] cycles_reg,  cycles_next;
    logic [CNT_W-1:0] budget_reg,  budget_next;
    logic [STG_W-1:0] stg_reg,     stg_next;
    logic [IDX_W-1:0] idx_reg,     idx_next;

    logic             idle_go;
    logic [CNT_W-1:0] idle_budget;

`ifdef RUN_CTRL_AUTOSTART_EN
    logic auto_reg;

    // High for exactly the first edge after internal reset release.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            auto_reg <= 1'b1;
        end else begin
            auto_reg <= 1'b0;
        end
    end

    assign idle_go     = auto_reg | start;
    assign idle_budget = auto_reg ? CNT_W'(DEFAULT_BUDGET) : budget;
`else
    assign idle_go     = start;
    assign idle_budget = budget;
`endif

    // One-hot mask of the domain addressed by the release index.
    logic [N_CH-1:0] release_mask;
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_release
        assign release_mask[gi] = (idx_reg == IDX_W'(gi));
    end

    always_comb begin
        state_next   = state_reg;
        rst_n_next   = rst_n_reg;
        running_next = running_reg;
        done_next    = done_reg;
        timeout_next = timeout_reg;
        cycles_next  = cycles_reg;
        budget_next  = budget_reg;
        stg_next     = stg_reg;
        idx_next     = idx_reg;

        case (state_reg)
            IDLE: begin
                if (idle_go) begin
                    budget_next = idle_budget;
                    stg_next    = '0;
                    idx_next    = '0;
                    state_next  = SEQ;
                end
            end
            SEQ: begin
                // stg counts down between releases; the first release is
                // on the edge after entry, so the counter starts at zero.
                if (idx_reg == IDX_W'(N_CH)) begin
                    state_next   = RUN;
                    running_next = 1'b1;
                end else if (stg_reg == '0) begin
                    rst_n_next = rst_n_reg | release_mask;
                    idx_next   = idx_reg + IDX_W'(1);
                    stg_next   = STG_W'(STAGGER - 1);
                end else begin
                    stg_next = stg_reg - STG_W'(1);
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_next   = DONE;
                    done_next    = 1'b1;
                    running_next = 1'b0;
                end else if ((budget_reg != '0) && (cycles_reg + CNT_W'(1) == budget_reg)) begin
                    state_next   = TIMEOUT;
                    cycles_next  = budget_reg;
                    timeout_next = 1'b1;
                    running_next = 1'b0;
                    rst_n_next   = '0;
                end else if (cycles_reg != '1) begin
                    cycles_next = cycles_reg + CNT_W'(1);
                end
            end
            DONE, TIMEOUT: begin
                if (start) begin
                    rst_n_next   = '0;
                    done_next    = 1'b0;
                    timeout_next = 1'b0;
                    cycles_next  = '0;
                    budget_next  = budget;
                    stg_next     = '0;
                    idx_next     = '0;
                    state_next   = SEQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rst_n_reg   <= '0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            cycles_reg  <= '0;
            budget_reg  <= '0;
            stg_reg     <= '0;
            idx_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            rst_n_reg   <= rst_n_next;
            running_reg <= running_next;
            done_reg    <= done_next;
            timeout_reg <= timeout_next;
            cycles_reg  <= cycles_next;
            budget_reg  <= budget_next;
            stg_reg     <= stg_next;
            idx_reg     <= idx_next;
        end
    end

    assign rst_n_out = rst_n_reg;
    assign running   = running_reg;
    assign done      = done_reg;
    assign timeout   = timeout_reg;
    assign cycles    = cycles_reg;

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller for the pipeline processor: synchronises the asynchronous reset, releases up to N_CH reset domains in a staggered sequence, then counts execution cycles against a programmable budget. It ends the run either on a halt request from the processor (done) or on budget exhaustion (timeout, which re-asserts all domain resets). It sits between the board reset/clock and the processor's per-domain active-low resets.

## Interface
- N_CH, 4: number of reset domains (1..16)
- STAGGER, 2: cycles between successive domain releases (≥1)
- CNT_W, 16: cycle counter / budget width
- SYNC_STAGES, 2: reset synchroniser depth (≥2)
- clk_50  in  1  system clock, single clock domain
- arst  in  1  reset, asynchronous, active-high
- start  in  1  run request, sampled each rising edge
- budget  in  CNT_W  cycle budget, latched on accepted start; 0 = unlimited
- halt_req  in  1  processor halt, sampled in RUN only
- rst_n_out  out  N_CH  per-domain active-low reset
- running  out  1  high in RUN
- done  out  1  run ended by halt_req
- timeout  out  1  run ended by budget exhaustion
- cycles  out  CNT_W  executed cycle count

## Operation
- Internal reset = arst, asserted asynchronously, deasserted after SYNC_STAGES clk_50 edges.
- Reset values: rst_n_out='0, running=0, done=0, timeout=0, cycles=0, state IDLE, latched budget=0.
- States: IDLE, SEQ, RUN, DONE, TIMEOUT.
- IDLE: start=1 → latch budget, SEQ.
- SEQ: domain k released (rst_n_out[k]=1) STAGGER*k+1 cycles after start accepted; lower indices first; released domains stay released. Edge after last release → RUN, running=1.
- RUN: each edge, halt_req=1 → DONE, done=1, cycles unchanged. Otherwise, budget≠0 and cycles+1==budget → TIMEOUT, cycles=budget, timeout=1, rst_n_out='0. Otherwise cycles+1, saturating at all-ones when budget=0.
- halt_req and budget exhaustion on the same edge: halt wins (DONE).
- DONE: domains stay released, cycles frozen, running=0.
- DONE/TIMEOUT: start=1 → rst_n_out='0, done/timeout/cycles cleared, budget re-latched, SEQ.
- start ignored in SEQ and RUN. halt_req ignored outside RUN.
- arst mid-operation: all outputs return to reset values immediately.

## Timing
- Start sampled at edge E0 → state SEQ at E0.
- rst_n_out[k] rises at E(1+k*STAGGER). running rises at E(2+(N_CH-1)*STAGGER).
- cycles first reaches 1 one edge after running rises.
- Timeout registered on the edge where cycles would reach budget. timeout and the rst_n_out drop are on the same edge.
- N_CH=1: release at E1, RUN at E2.
- done/timeout are levels, held until the next accepted start or reset.

## Configuration
- RUN_CTRL_AUTOSTART_EN defined: one cycle after internal reset release, an implicit start is taken with budget = DEFAULT_BUDGET (500). The start port still works in DONE/TIMEOUT.
- Undefined: IDLE is left only via the start port.

## Structure
- Package run_ctrl_pkg: state enum run_state_t {IDLE, SEQ, RUN, DONE, TIMEOUT}, constant DEFAULT_BUDGET=500.
- Sub-module rst_sync: SYNC_STAGES-deep asynchronous-assert / synchronous-deassert reset synchroniser producing the internal reset.
- Top holds the FSM, the stagger counter, the release-index counter and the cycle counter.

## Test plan
- Reset: arst=1 → all outputs 0. Deassert → internal reset released after 2 edges, state IDLE.
- N_CH=4, STAGGER=2, start at E0 with budget=0 → rst_n_out 0001@E1, 0011@E3, 0111@E5, 1111@E7, running@E8. Running for 20 cycles → cycles=20.
- budget=5 with no halt → cycles=5, timeout=1, rst_n_out=0000 on the same edge, running=0.
- budget=5 with halt_req on the edge where cycles would reach 5 → done=1, timeout=0, cycles=4, rst_n_out=1111.
- arst during SEQ after two domains are released → rst_n_out=0000 immediately. start during RUN → no effect. start in DONE → resets re-asserted, sequence restarts.
- RUN_CTRL_AUTOSTART_EN defined, no start pulse → run begins automatically, timeout at cycles=500.
